// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage handshake bundle: imem request/response, redirect, decode
interface fetch_stage_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   modport master (
      output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, in-order slot queue, redirect flush
// Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus,
   output logic          misalign_err
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_stall
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int DW = 8;

   typedef enum logic {RUN, HALT} state_t;

   state_t          state, state_nxt;
   logic [31:0]     pc, pc_nxt;
   logic [AW:0]     head, tail, fptr;
   logic [DW-1:0]   drop_cnt, drop_nxt;
   logic [31:0]     slot_pc    [FIFO_DEPTH];
   logic [31:0]     slot_instr [FIFO_DEPTH];
   logic            full, accept, fill, pop, misaligned;
   logic [AW:0]     unfilled;

   // head..fptr are filled slots, fptr..tail are awaiting a response
   assign full       = (tail - head) == (AW+1)'(FIFO_DEPTH);
   assign unfilled   = tail - fptr;
   assign misaligned = bus.redirect_pc[1:0] != 2'b00;

   assign bus.imem_req_valid = !reset && (state == RUN) && !full;
   assign bus.imem_req_addr  = pc;
   assign bus.id_valid       = (fptr != head);
   assign bus.id_pc          = bus.id_valid ? slot_pc[head[AW-1:0]] : 32'h0;
   assign bus.id_instr       = bus.id_valid ? slot_instr[head[AW-1:0]] : 32'h0;

   assign accept = bus.imem_req_valid && bus.imem_req_ready;
   assign fill   = bus.imem_rsp_valid && (drop_cnt == '0);
   assign pop    = bus.id_valid && bus.id_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      drop_nxt  = drop_cnt;
      if (bus.imem_rsp_valid && (drop_cnt != '0))
         drop_nxt = drop_cnt - 1'b1;
      if (accept)
         pc_nxt = pc + 32'd4;
      if (bus.redirect_valid) begin
         // same-cycle response is dropped either way, so it retires one outstanding request
         drop_nxt  = drop_cnt + DW'(unfilled) + DW'(accept) - DW'(bus.imem_rsp_valid);
         pc_nxt    = bus.redirect_pc;
         state_nxt = misaligned ? HALT : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         pc           <= RESET_PC;
         head         <= '0;
         tail         <= '0;
         fptr         <= '0;
         drop_cnt     <= '0;
         misalign_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         drop_cnt <= drop_nxt;
         if (bus.redirect_valid) begin
            head <= '0;
            tail <= '0;
            fptr <= '0;
            if (misaligned)
               misalign_err <= 1'b1;
         end else begin
            if (accept) tail <= tail + 1'b1;
            if (fill)   fptr <= fptr + 1'b1;
            if (pop)    head <= head + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) slot_pc[tail[AW-1:0]]    <= pc;
      if (fill)   slot_instr[fptr[AW-1:0]] <= bus.imem_rsp_data;
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= 32'h0;
         perf_stall   <= 32'h0;
      end else begin
         if (pop)
            perf_fetched <= perf_fetched + 32'd1;
         if ((bus.id_valid && !bus.id_ready) || (state == RUN && !bus.id_valid))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule
